// File: rtl/dram_frame_scheduler.sv
// dram_frame_scheduler: merges addressed chunk writers and a linear display read stream onto one DRAM request port
module dram_frame_scheduler #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 24,
  parameter int H_ACTIVE        = 1280,
  parameter int V_ACTIVE        = 720,
  parameter int PIXEL_WIDTH     = 16,
  parameter int NUM_WRITERS     = 2,
  parameter int DOUBLE_BUFFER   = 1,
  parameter int MAX_OUTSTANDING = 8,
  parameter int READ_RUN_MAX    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_WRITERS-1:0]            wr_valid,
  output logic [NUM_WRITERS-1:0]            wr_ready,
  input  logic [NUM_WRITERS*DATA_WIDTH-1:0] wr_data,
  input  logic [NUM_WRITERS*ADDR_WIDTH-1:0] wr_addr,
  input  logic                              swap_req,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic                              rd_valid,
  output logic                              rd_last,
  input  logic                              rd_ready,
  input  logic                              rd_almost_full,
  output logic                              mem_en,
  output logic                              mem_we,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  input  logic                              mem_busy,
  input  logic                              mem_ack,
  input  logic [DATA_WIDTH-1:0]             mem_rdata,
  output logic                              front_buf,
  output logic                              overflow_err
);
  localparam int CHUNKS = H_ACTIVE * V_ACTIVE * PIXEL_WIDTH / DATA_WIDTH;
  localparam int PW = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  localparam int RW = $clog2(READ_RUN_MAX + 1);
  localparam int WW = NUM_WRITERS > 1 ? $clog2(NUM_WRITERS) : 1;
  localparam int TW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int TD = 1 << TW;
  localparam int CW = TW + 1;
  logic [PW-1:0] rd_ptr;
  logic [RW-1:0] read_run;
  logic [WW-1:0] rr, g;
  logic swap_pend, mem_last;
  logic [1:0] trk [TD];
  logic [TW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic accept, load, room, rd_elig, wr_elig, pick_wr, pick_rd, wrap, wr_hit, swap_any, ack_v, wbuf;
  logic [ADDR_WIDTH-1:0] wa, raddr, waddr;
  logic [DATA_WIDTH-1:0] wd;
  always_comb begin
    g = '0;
    for (int k = NUM_WRITERS - 1; k >= 0; k--)
      if (wr_valid[(int'(rr) + k) % NUM_WRITERS]) g = WW'((int'(rr) + k) % NUM_WRITERS);
  end
  assign accept   = mem_en && !mem_busy;
  assign load     = !mem_en || !mem_busy;
  assign room     = cnt < CW'(MAX_OUTSTANDING);
  assign rd_elig  = !rd_almost_full && room;
  assign wr_elig  = |wr_valid && room;
  assign pick_wr  = load && wr_elig && (!rd_elig || read_run == RW'(READ_RUN_MAX));
  assign pick_rd  = load && rd_elig && !pick_wr;
  assign wr_ready = (rst_n && pick_wr) ? NUM_WRITERS'(1) << g : '0;
  assign wa       = wr_addr[int'(g)*ADDR_WIDTH +: ADDR_WIDTH];
  assign wd       = wr_data[int'(g)*DATA_WIDTH +: DATA_WIDTH];
  assign wr_hit   = wa < ADDR_WIDTH'(CHUNKS);
  assign wbuf     = DOUBLE_BUFFER != 0 ? ~front_buf : front_buf;
  assign raddr    = (ADDR_WIDTH'(front_buf) << PW) | ADDR_WIDTH'(rd_ptr);
  assign waddr    = (ADDR_WIDTH'(wbuf) << PW) | wa;
  assign wrap     = rd_ptr == PW'(CHUNKS - 1);
  assign swap_any = DOUBLE_BUFFER != 0 && (swap_pend || swap_req);
  assign ack_v    = mem_ack && cnt != '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_last     <= 1'b0;
      rd_valid     <= 1'b0;
      rd_last      <= 1'b0;
      rd_data      <= '0;
      front_buf    <= 1'b0;
      overflow_err <= 1'b0;
      rd_ptr       <= '0;
      read_run     <= '0;
      rr           <= '0;
      swap_pend    <= 1'b0;
      wp           <= '0;
      rp           <= '0;
      cnt          <= '0;
    end else begin
      if (load) begin
        mem_en   <= pick_rd || (pick_wr && wr_hit);
        mem_we   <= pick_wr && wr_hit;
        mem_addr <= pick_wr ? waddr : raddr;
        mem_last <= wrap;
      end
      if (pick_wr) begin
        mem_wdata <= wd;
        read_run  <= '0;
        rr        <= int'(g) == NUM_WRITERS - 1 ? '0 : g + 1'b1;
      end
      if (pick_rd) begin
        rd_ptr   <= wrap ? '0 : rd_ptr + 1'b1;
        read_run <= read_run == RW'(READ_RUN_MAX) ? read_run : read_run + 1'b1;
      end
      if (pick_rd && wrap && swap_any) begin
        front_buf <= ~front_buf;
        swap_pend <= 1'b0;
      end else if (swap_req && DOUBLE_BUFFER != 0) begin
        swap_pend <= 1'b1;
      end
      if (accept) begin
        trk[wp] <= {mem_we, mem_last};
        wp      <= wp + 1'b1;
      end
      if (ack_v) rp <= rp + 1'b1;
      cnt <= cnt + CW'(accept) - CW'(ack_v);
      if (ack_v && !trk[rp][1]) begin
        if (rd_valid && !rd_ready) begin
          overflow_err <= 1'b1;
        end else begin
          rd_valid <= 1'b1;
          rd_data  <= mem_rdata;
          rd_last  <= trk[rp][0];
        end
      end else if (rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dram_frame_scheduler.sv
// tb_dram_frame_scheduler: directed vectors plus randomized traffic against a transaction-level model
module tb_dram_frame_scheduler;
  localparam int DW = 128, AW = 24, NW = 2, CH = 4, MO = 8, RRM = 16;
  logic clk = 0, rst_n = 0;
  logic [NW-1:0] wr_valid = '0, wr_ready;
  logic [NW*DW-1:0] wr_data = '0;
  logic [NW*AW-1:0] wr_addr = '0;
  logic swap_req = 0, rd_valid, rd_last, rd_ready = 1, rd_almost_full = 0;
  logic [DW-1:0] rd_data, mem_wdata, mem_rdata = '0;
  logic mem_en, mem_we, mem_busy = 0, mem_ack = 0, front_buf, overflow_err;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;
  dram_frame_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .H_ACTIVE(16), .V_ACTIVE(2), .PIXEL_WIDTH(16),
    .NUM_WRITERS(NW), .DOUBLE_BUFFER(1), .MAX_OUTSTANDING(MO), .READ_RUN_MAX(RRM)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
    .swap_req(swap_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .rd_almost_full(rd_almost_full), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .front_buf(front_buf), .overflow_err(overflow_err));
  int checks = 0, failures = 0;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask
  typedef struct {bit we; bit last;} trk_t;
  trk_t memq[$];
  bit m_front, m_swap, m_reg_last, auto_ack = 1;
  int m_ptr, m_rr, m_run, ack_pct = 100, p_g;
  bit e_en, e_we, e_rdv, e_last, e_ovf;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata, p_ack_data;
  bit p_rst, p_load, p_acc, p_ack, p_af, p_rdr, p_swap, p_exp_wr, p_exp_rd;
  logic [NW-1:0] s_grant;
  logic [AW-1:0] p_wa[NW];
  logic [DW-1:0] p_wd[NW];
  task automatic tick();
    int out;
    bit found, rd_ack;
    trk_t h;
    #1;
    p_rst = !rst_n;
    out = memq.size();
    p_load = !e_en || !mem_busy;
    p_acc = e_en && !mem_busy;
    p_af = rd_almost_full;
    p_rdr = rd_ready;
    p_swap = swap_req;
    p_ack = mem_ack;
    p_ack_data = mem_rdata;
    for (int i = 0; i < NW; i++) begin
      p_wa[i] = wr_addr[i*AW +: AW];
      p_wd[i] = wr_data[i*DW +: DW];
    end
    found = 0;
    p_g = 0;
    for (int k = 0; k < NW; k++)
      if (!found && wr_valid[(m_rr + k) % NW]) begin
        p_g = (m_rr + k) % NW;
        found = 1;
      end
    p_exp_wr = rst_n && p_load && found && out < MO && (p_af || m_run == RRM);
    p_exp_rd = rst_n && p_load && !p_af && out < MO && !p_exp_wr;
    s_grant = wr_ready;
    chk("wr_ready", wr_ready, p_exp_wr ? 128'(1) << p_g : 128'(0));
    @(posedge clk);
    @(negedge clk);
    if (p_rst) begin
      memq.delete();
      {m_front, m_swap, m_reg_last, e_en, e_we, e_rdv, e_last, e_ovf} = '0;
      m_ptr = 0; m_rr = 0; m_run = 0;
      e_addr = '0; e_wdata = '0; e_rdata = '0;
    end else begin
      rd_ack = 0;
      if (p_ack && memq.size() > 0) begin
        h = memq.pop_front();
        rd_ack = !h.we;
      end
      if (rd_ack) begin
        if (e_rdv && !p_rdr) e_ovf = 1;
        else begin
          e_rdv = 1;
          e_rdata = p_ack_data;
          e_last = h.last;
        end
      end else if (p_rdr) e_rdv = 0;
      if (p_acc) memq.push_back(trk_t'{e_we, m_reg_last});
      m_swap |= p_swap;
      if (p_exp_wr) begin
        m_rr = (p_g + 1) % NW;
        m_run = 0;
        e_en = p_wa[p_g] < CH;
        e_we = e_en;
        if (e_en) begin
          e_addr = AW'(!m_front) * CH + p_wa[p_g];
          e_wdata = p_wd[p_g];
        end
      end else if (p_exp_rd) begin
        e_en = 1;
        e_we = 0;
        e_addr = AW'(m_front) * CH + AW'(m_ptr);
        m_reg_last = m_ptr == CH - 1;
        if (m_ptr == CH - 1) begin
          m_ptr = 0;
          if (m_swap) begin
            m_front = !m_front;
            m_swap = 0;
          end
        end else m_ptr++;
        if (m_run < RRM) m_run++;
      end else if (p_load) e_en = 0;
    end
    chk("mem_en", mem_en, e_en);
    if (e_en) begin
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
    end
    chk("front_buf", front_buf, m_front);
    chk("rd_valid", rd_valid, e_rdv);
    chk("overflow_err", overflow_err, e_ovf);
    if (e_rdv) begin
      chk("rd_data", rd_data, e_rdata);
      chk("rd_last", rd_last, e_last);
    end
    if (auto_ack) begin
      mem_ack = memq.size() > 0 && $urandom_range(0, 99) < ack_pct;
      mem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask
  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask
  task automatic chk_reset_outputs();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_front_buf", front_buf, 0);
    chk("rst_overflow", overflow_err, 0);
  endtask
  typedef struct {
    logic [1:0] wv;
    logic [AW-1:0] a0, a1;
    bit af;
    logic [1:0] g;
    bit en, we;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t tbl[11];
  logic [DW-1:0] wd0, wd1;
  int n, w1, w2;
  initial begin
    tbl[0]  = '{2'b00, 0, 0, 0, 2'b00, 1, 0, 0};
    tbl[1]  = '{2'b00, 0, 0, 0, 2'b00, 1, 0, 1};
    tbl[2]  = '{2'b01, 2, 0, 1, 2'b01, 1, 1, 6};
    tbl[3]  = '{2'b11, 2, 2, 1, 2'b10, 1, 1, 6};
    tbl[4]  = '{2'b11, 2, 2, 1, 2'b01, 1, 1, 6};
    tbl[5]  = '{2'b00, 0, 0, 0, 2'b00, 1, 0, 2};
    tbl[6]  = '{2'b00, 0, 0, 0, 2'b00, 1, 0, 3};
    tbl[7]  = '{2'b00, 0, 0, 0, 2'b00, 1, 0, 0};
    tbl[8]  = '{2'b00, 0, 0, 1, 2'b00, 0, 0, 0};
    tbl[9]  = '{2'b10, 0, 5, 1, 2'b10, 0, 0, 0};
    tbl[10] = '{2'b01, 3, 0, 1, 2'b01, 1, 1, 7};
    tick();
    do_reset();
    chk_reset_outputs();
    for (int i = 0; i < 11; i++) begin
      wr_valid = tbl[i].wv;
      wr_addr = {tbl[i].a1, tbl[i].a0};
      rd_almost_full = tbl[i].af;
      wr_data = {4{$urandom()}};
      tick();
      chk("vec_grant", s_grant, tbl[i].g);
      chk("vec_en", mem_en, tbl[i].en);
      chk("vec_we", mem_we, tbl[i].we);
      if (tbl[i].en) chk("vec_addr", mem_addr, tbl[i].addr);
    end
    rd_almost_full = 0;
    wr_valid = 2'b01;
    wr_addr = {AW'(0), AW'(1)};
    w1 = -1;
    w2 = -1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (mem_en) begin
        if (mem_we && w1 < 0) w1 = n;
        else if (mem_we && w2 < 0) w2 = n;
        n++;
      end
    end
    chk("starve_first_write", w1, RRM);
    chk("starve_second_write", w2, 2 * RRM + 1);
    wr_valid = '0;
    do_reset();
    tick();
    swap_req = 1;
    tick();
    swap_req = 0;
    chk("swap_hold_rd1", front_buf, 0);
    tick();
    chk("swap_hold_rd2", front_buf, 0);
    tick();
    chk("swap_wrap_addr", mem_addr, 3);
    chk("swap_toggled", front_buf, 1);
    tick();
    chk("swap_next_read", mem_addr, 4);
    rd_almost_full = 1;
    wr_valid = 2'b01;
    wr_addr = '0;
    wd0 = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr_data = {DW'(0), wd0};
    tick();
    chk("swap_write_addr", mem_addr, 0);
    chk("swap_write_we", mem_we, 1);
    wd1 = {$urandom(), $urandom(), $urandom(), $urandom()};
    wr_data = {DW'(0), wd1};
    mem_busy = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_no_grant", s_grant, 0);
      chk("busy_addr", mem_addr, 0);
      chk("busy_wdata", mem_wdata, wd0);
    end
    mem_busy = 0;
    tick();
    chk("busy_release_grant", s_grant, 2'b01);
    chk("busy_release_wdata", mem_wdata, wd1);
    wr_valid = '0;
    for (int i = 0; i < 4; i++) tick();
    auto_ack = 0;
    mem_ack = 1;
    tick();
    mem_ack = 0;
    auto_ack = 1;
    chk("empty_ack_rd_valid", rd_valid, 0);
    rd_ready = 0;
    rd_almost_full = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("ovf_set", overflow_err, 1);
    rd_ready = 1;
    rd_almost_full = 1;
    for (int i = 0; i < 3; i++) tick();
    chk("ovf_sticky", overflow_err, 1);
    do_reset();
    chk_reset_outputs();
    ack_pct = 60;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NW; i++)
        if (!wr_valid[i] || s_grant[i]) begin
          wr_valid[i] = $urandom_range(0, 2) != 0;
          wr_addr[i*AW +: AW] = AW'($urandom_range(0, 4));
          wr_data[i*DW +: DW] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      rd_almost_full = $urandom_range(0, 3) == 0;
      mem_busy = $urandom_range(0, 4) == 0;
      swap_req = $urandom_range(0, 30) == 0;
      rd_ready = $urandom_range(0, 7) != 0;
      rst_n = c != 1500;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dram_frame_scheduler.md
# dram_frame_scheduler

Parametrised DRAM request scheduler for the frame-buffer pipeline, in the memory-controller clock domain between the clock-crossing FIFOs and the DDR3 controller's wishbone-style port. It merges NUM_WRITERS addressed chunk-write streams with a linear display-prefetch read stream. It adds optional double buffering with frame-boundary swaps, write-starvation protection and in-order ack routing.

## Interface
- DATA_WIDTH, 128: bits per memory chunk.
- ADDR_WIDTH, 24: chunk-addressed memory address width.
- H_ACTIVE, 1280 / V_ACTIVE, 720 / PIXEL_WIDTH, 16: frame geometry.
- NUM_WRITERS, 2: write channel count, 1..4.
- DOUBLE_BUFFER, 1: 1 = reads and writes target separate buffers; 0 = single shared buffer.
- MAX_OUTSTANDING, 8: in-flight request limit, power of 2.
- READ_RUN_MAX, 16: consecutive read issues before a waiting writer is forced in.
- clk  in  1  controller clock.
- rst_n  in  1  reset. **One clock; reset is synchronous and active-low.**
- wr_valid  in  NUM_WRITERS  per-writer chunk valid.
- wr_ready  out  NUM_WRITERS  per-writer accept.
- wr_data  in  NUM_WRITERS*DATA_WIDTH  chunk data, writer i at slice i.
- wr_addr  in  NUM_WRITERS*ADDR_WIDTH  chunk index within frame, 0..CHUNKS-1.
- swap_req  in  1  pulse: request front/back buffer swap.
- rd_data  out  DATA_WIDTH  display chunk.
- rd_valid / rd_last  out  1  chunk valid; last chunk of frame.
- rd_ready  in  1  downstream accept.
- rd_almost_full  in  1  downstream FIFO has fewer than MAX_OUTSTANDING+1 free slots.
- mem_en / mem_we  out  1  request strobe; 1 = write.
- mem_addr  out  ADDR_WIDTH  request address.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_busy  in  1  controller stall.
- mem_ack  in  1  completion pulse, in issue order.
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack.
- front_buf  out  1  buffer currently displayed.
- overflow_err  out  1  sticky error flag.

## Operation
- CHUNKS = H_ACTIVE*V_ACTIVE*PIXEL_WIDTH/DATA_WIDTH; STRIDE = 2^ceil(log2(CHUNKS)).
- Read address = front_buf*STRIDE + rd_ptr.
- Write address = (DOUBLE_BUFFER ? ~front_buf : front_buf)*STRIDE + wr_addr. wr_addr ≥ CHUNKS is accepted and dropped, with no memory request.
- Request register holds mem_en/mem_we/mem_addr/mem_wdata. A request is accepted on a cycle with mem_en && !mem_busy. The register loads when empty or accepted that cycle, so back-to-back issue is allowed. Contents are stable while stalled.
- Issue candidates:
  - Read is eligible when !rd_almost_full and outstanding < MAX_OUTSTANDING.
  - Write is eligible when any wr_valid and outstanding < MAX_OUTSTANDING.
- Priority:
  - Read wins unless read_run == READ_RUN_MAX and a write is eligible.
  - Writers are granted round-robin, starting after the last granted index.
  - read_run increments on each read load and clears on each write load.
- wr_ready[i] is combinational: the grant to i in a cycle the register loads.
- rd_ptr increments per read load and wraps CHUNKS-1 → 0. On the wrap, a latched swap_req (DOUBLE_BUFFER=1 only) toggles front_buf and clears the latch. A swap never occurs mid-frame.
- Tracker FIFO stores {we, last} per accepted request. outstanding = entries.
  - On mem_ack, pop. If read: rd_valid=1, rd_data=mem_rdata, rd_last=last. If write: discard.
  - A mem_ack with an empty tracker is ignored.
- Read ack while rd_valid && !rd_ready: data is dropped and overflow_err is set. Held until reset.
- Simultaneous accept and ack: outstanding unchanged.

## Timing
- Reset values:
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - rd_valid=0, rd_last=0, rd_data=0.
  - wr_ready=0, front_buf=0, overflow_err=0.
  - rd_ptr=0, read_run=0, RR pointer=0, tracker empty, swap latch clear.
- wr_valid/candidate sampled in cycle N → mem_en high in cycle N+1.
- mem_ack in cycle N → rd_valid in cycle N+1, held until rd_ready.
- swap_req in the cycle of the wrap load → front_buf toggles the next cycle, affecting the next read load.
- Reset mid-operation discards in-flight tracking. The controller is reset in the same cycle.

## Test plan
- Geometry H=16, V=2, DATA=128 (CHUNKS=4, STRIDE=4); rd_almost_full=0, rd_ready=1, writers idle, no swap → mem_addr 0,1,2,3,0…; rd_last on every 4th rd_valid; front_buf stays 0.
- Writers 0 and 1 valid continuously at wr_addr 2, rd_almost_full=1 → grants alternate 0,1,0,1; mem_we=1; mem_addr=6 (back buffer 1).
- rd_almost_full=0 with writer 0 valid, READ_RUN_MAX=16 → 16 reads, then 1 write, then reads resume.
- swap_req pulsed when rd_ptr=1 → front_buf toggles only after the read of chunk 3. The next read address is 4, and the next write to wr_addr 0 goes to 0.
- mem_busy held for 5 cycles with a pending write → mem_addr/mem_wdata stable; no wr_ready asserted.
- Read ack with rd_ready=0 and rd_valid=1 → overflow_err=1 and stays 1. Then rst_n=0 for 1 cycle → all outputs at reset values.
